rvfi_pc_link_check: RTL and testbench

Parametrised RVFI PC-continuity checker for an N-channel retirement port. It tracks one target instruction, selected by `instruction_order`, and its two order-neighbours, which may retire in any channel and any cycle. It checks both backward linkage (successor `pc_rdata` equals target `pc_wdata`) and forward linkage (target `pc_rdata` equals predecessor `pc_wdata`). Linkage checks are waived across interrupts, and a bounded-liveness timeout flags a successor that never arrives. The block sits beside the other RVFI checks in the formal and simulation harness, and reports through sticky fail flags that the harness asserts on.

---
 rtl/rvfi_check_pkg.sv | 28 ++
 rtl/rvfi_pc_link_check_match.sv | 41 ++++
 rtl/rvfi_pc_link_check.sv | 210 +++++++++++++++++++++
 tb/tb_rvfi_pc_link_check.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_check_pkg.sv
// Shared types and helpers for the RVFI PC-continuity checker.
// Holds the timeout FSM states, the order offsets and the aligned PC compare.
package rvfi_check_pkg;

    typedef enum logic [1:0] {
        PCL_IDLE = 2'd0,
        PCL_WAIT = 2'd1,
        PCL_DONE = 2'd2
    } pcl_state_e;

    // Order offsets of the tracked records relative to instruction_order (64-bit modulo).
    localparam logic [63:0] ORD_OFF_PRED = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ORD_OFF_TGT  = 64'd0;
    localparam logic [63:0] ORD_OFF_SUCC = 64'd1;

    localparam int unsigned PC_MAX_W = 64;

    function automatic logic pc_eq(
        input logic [PC_MAX_W-1:0] a,
        input logic [PC_MAX_W-1:0] b,
        input int unsigned         align_lsb
    );
        logic [PC_MAX_W-1:0] mask;
        mask = '1 << align_lsb;
        return ((a ^ b) & mask) == '0;
    endfunction

endpackage

// File: rtl/rvfi_pc_link_check_match.sv
// Per-offset retirement matcher: finds channels retiring a given order,
// picks the lowest-index one and flags same-cycle multiple hits.
module rvfi_order_match
    import rvfi_check_pkg::*;
#(
    parameter int unsigned NRET = 1,
    parameter int unsigned W    = 1
) (
    input  logic [63:0]        key_i,
    input  logic [NRET-1:0]    valid_i,
    input  logic [64*NRET-1:0] order_i,
    input  logic [W*NRET-1:0]  payload_i,
    output logic [NRET-1:0]    match_o,
    output logic [NRET-1:0]    sel_o,
    output logic               multi_o,
    output logic [W-1:0]       payload_o
);

    logic found;

    always_comb begin
        match_o   = '0;
        sel_o     = '0;
        multi_o   = 1'b0;
        payload_o = '0;
        found     = 1'b0;
        for (int unsigned ch = 0; ch < NRET; ch++) begin
            if (valid_i[ch] && (order_i[ch*64 +: 64] == key_i)) begin
                match_o[ch] = 1'b1;
                if (found) begin
                    multi_o = 1'b1;
                end else begin
                    sel_o[ch] = 1'b1;
                    payload_o = payload_i[ch*W +: W];
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rvfi_pc_link_check.sv
// RVFI PC-continuity checker: links the target instruction to its order
// neighbours and raises sticky fail flags on broken PC chains or a late successor.
module rvfi_pc_link_check
    import rvfi_check_pkg::*;
#(
    parameter int unsigned NRET      = 1,
    parameter int unsigned XLEN      = 32,
    parameter bit          CHECK_BWD = 1'b1,
    parameter bit          CHECK_FWD = 1'b1,
    parameter int unsigned ALIGN_LSB = 1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 check,
    input  logic [63:0]          instruction_order,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
    input  logic [NRET-1:0]      rvfi_intr,
    output logic                 bwd_fail,
    output logic                 fwd_fail,
    output logic                 dup_fail,
    output logic                 timeout_fail,
    output logic                 bwd_done,
    output logic                 fwd_done
);

    localparam int unsigned     CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam int unsigned     TW        = 2 * XLEN + 1;
    localparam int unsigned     SW        = XLEN + 1;

    logic [TW*NRET-1:0] tgt_pay;
    logic [SW*NRET-1:0] succ_pay;

    always_comb begin
        tgt_pay  = '0;
        succ_pay = '0;
        for (int unsigned ch = 0; ch < NRET; ch++) begin
            tgt_pay[ch*TW +: TW]  = {rvfi_intr[ch], rvfi_pc_wdata[ch*XLEN +: XLEN],
                                     rvfi_pc_rdata[ch*XLEN +: XLEN]};
            succ_pay[ch*SW +: SW] = {rvfi_intr[ch], rvfi_pc_rdata[ch*XLEN +: XLEN]};
        end
    end

    logic [NRET-1:0] pred_match, pred_sel, tgt_match, tgt_sel, succ_match, succ_sel;
    logic            pred_multi, tgt_multi, succ_multi;
    logic [XLEN-1:0] pred_pay_sel;
    logic [TW-1:0]   tgt_pay_sel;
    logic [SW-1:0]   succ_pay_sel;

    rvfi_order_match #(.NRET(NRET), .W(XLEN)) u_match_pred (
        .key_i     (instruction_order + ORD_OFF_PRED),
        .valid_i   (rvfi_valid),
        .order_i   (rvfi_order),
        .payload_i (rvfi_pc_wdata),
        .match_o   (pred_match),
        .sel_o     (pred_sel),
        .multi_o   (pred_multi),
        .payload_o (pred_pay_sel)
    );

    rvfi_order_match #(.NRET(NRET), .W(TW)) u_match_tgt (
        .key_i     (instruction_order + ORD_OFF_TGT),
        .valid_i   (rvfi_valid),
        .order_i   (rvfi_order),
        .payload_i (tgt_pay),
        .match_o   (tgt_match),
        .sel_o     (tgt_sel),
        .multi_o   (tgt_multi),
        .payload_o (tgt_pay_sel)
    );

    rvfi_order_match #(.NRET(NRET), .W(SW)) u_match_succ (
        .key_i     (instruction_order + ORD_OFF_SUCC),
        .valid_i   (rvfi_valid),
        .order_i   (rvfi_order),
        .payload_i (succ_pay),
        .match_o   (succ_match),
        .sel_o     (succ_sel),
        .multi_o   (succ_multi),
        .payload_o (succ_pay_sel)
    );

    logic            pred_vld_q, tgt_vld_q, succ_vld_q;
    logic [XLEN-1:0] pred_wdata_q, tgt_rdata_q, tgt_wdata_q, succ_rdata_q;
    logic            tgt_intr_q, succ_intr_q;

    logic pred_hit, tgt_hit, succ_hit;
    logic pred_load, tgt_load, succ_load;
    logic dup_now;

    assign pred_hit  = |pred_match;
    assign tgt_hit   = |tgt_match;
    assign succ_hit  = |succ_match;
    assign pred_load = (|pred_sel) && !pred_vld_q;
    assign tgt_load  = (|tgt_sel) && !tgt_vld_q;
    assign succ_load = (|succ_sel) && !succ_vld_q;
    assign dup_now   = pred_multi || (pred_hit && pred_vld_q)
                    || tgt_multi  || (tgt_hit && tgt_vld_q)
                    || succ_multi || (succ_hit && succ_vld_q);

    // Compares run on registered records, so done/fail show in the cycle after capture.
    logic bwd_fire, bwd_bad, fwd_fire, fwd_bad;
    logic bwd_done_q, bwd_fail_q, fwd_done_q, fwd_fail_q, dup_fail_q, timeout_fail_q;
    logic bwd_done_d, bwd_fail_d, fwd_done_d, fwd_fail_d, dup_fail_d, timeout_fail_d;

    assign bwd_fire = CHECK_BWD && tgt_vld_q && succ_vld_q && !bwd_done_q;
    assign bwd_bad  = !succ_intr_q &&
                      !pc_eq(PC_MAX_W'(succ_rdata_q), PC_MAX_W'(tgt_wdata_q), ALIGN_LSB);
    assign fwd_fire = CHECK_FWD && pred_vld_q && tgt_vld_q && !fwd_done_q;
    assign fwd_bad  = !tgt_intr_q &&
                      !pc_eq(PC_MAX_W'(tgt_rdata_q), PC_MAX_W'(pred_wdata_q), ALIGN_LSB);

    assign bwd_done_d = bwd_done_q | bwd_fire;
    assign bwd_fail_d = bwd_fail_q | (bwd_fire & bwd_bad & check);
    assign fwd_done_d = fwd_done_q | fwd_fire;
    assign fwd_fail_d = fwd_fail_q | (fwd_fire & fwd_bad & check);
    assign dup_fail_d = dup_fail_q | (dup_now & check);

    pcl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            to_expire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_expire = 1'b0;
        unique case (state_q)
            PCL_IDLE: begin
                cnt_d = '0;
                if (tgt_load) begin
                    state_d = (succ_vld_q || succ_hit) ? PCL_DONE : PCL_WAIT;
                end
            end
            PCL_WAIT: begin
                if (succ_hit) begin
                    state_d = PCL_DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_LIMIT) begin
                        state_d   = PCL_DONE;
                        to_expire = 1'b1;
                    end
                end
            end
            PCL_DONE: begin
                state_d = PCL_DONE;
            end
            default: begin
                state_d = PCL_IDLE;
            end
        endcase
    end

    assign timeout_fail_d = timeout_fail_q | (to_expire & check);

    always_ff @(posedge clock) begin
        if (reset) begin
            pred_vld_q     <= 1'b0;
            tgt_vld_q      <= 1'b0;
            succ_vld_q     <= 1'b0;
            pred_wdata_q   <= '0;
            tgt_rdata_q    <= '0;
            tgt_wdata_q    <= '0;
            tgt_intr_q     <= 1'b0;
            succ_rdata_q   <= '0;
            succ_intr_q    <= 1'b0;
            bwd_done_q     <= 1'b0;
            bwd_fail_q     <= 1'b0;
            fwd_done_q     <= 1'b0;
            fwd_fail_q     <= 1'b0;
            dup_fail_q     <= 1'b0;
            timeout_fail_q <= 1'b0;
            state_q        <= PCL_IDLE;
            cnt_q          <= '0;
        end else begin
            if (pred_load) begin
                pred_vld_q   <= 1'b1;
                pred_wdata_q <= pred_pay_sel;
            end
            if (tgt_load) begin
                tgt_vld_q <= 1'b1;
                {tgt_intr_q, tgt_wdata_q, tgt_rdata_q} <= tgt_pay_sel;
            end
            if (succ_load) begin
                succ_vld_q <= 1'b1;
                {succ_intr_q, succ_rdata_q} <= succ_pay_sel;
            end
            bwd_done_q     <= bwd_done_d;
            bwd_fail_q     <= bwd_fail_d;
            fwd_done_q     <= fwd_done_d;
            fwd_fail_q     <= fwd_fail_d;
            dup_fail_q     <= dup_fail_d;
            timeout_fail_q <= timeout_fail_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bwd_done     = bwd_done_d;
    assign bwd_fail     = bwd_fail_d;
    assign fwd_done     = fwd_done_d;
    assign fwd_fail     = fwd_fail_d;
    assign dup_fail     = dup_fail_q;
    assign timeout_fail = timeout_fail_q;

endmodule

// File: tb/tb_rvfi_pc_link_check.sv
// Self-checking bench for rvfi_pc_link_check: directed scenarios plus randomized
// retirement traffic scored against an event-history reference model.
module tb_rvfi_pc_link_check;

    localparam int unsigned NRET  = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ALIGN = 1;
    localparam int unsigned TMO   = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 check;
    logic [63:0]          instruction_order;
    logic [NRET-1:0]      rvfi_valid;
    logic [64*NRET-1:0]   rvfi_order;
    logic [XLEN*NRET-1:0] rvfi_pc_rdata;
    logic [XLEN*NRET-1:0] rvfi_pc_wdata;
    logic [NRET-1:0]      rvfi_intr;
    logic bwd_fail, fwd_fail, dup_fail, timeout_fail, bwd_done, fwd_done;

    always #5 clock = ~clock;

    rvfi_pc_link_check #(
        .NRET(NRET), .XLEN(XLEN), .CHECK_BWD(1'b1), .CHECK_FWD(1'b1),
        .ALIGN_LSB(ALIGN), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .check(check),
        .instruction_order(instruction_order),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_intr(rvfi_intr),
        .bwd_fail(bwd_fail), .fwd_fail(fwd_fail), .dup_fail(dup_fail),
        .timeout_fail(timeout_fail), .bwd_done(bwd_done), .fwd_done(fwd_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_hist [0:8191];

    // Model: first-capture cycle and payload of orders T-1, T, T+1 (index 0,1,2).
    int          fc [3];
    logic [31:0] m_r [3];
    logic [31:0] m_w [3];
    bit          m_i [3];
    int          dup_j;

    function automatic bit pc_same(input logic [31:0] a, input logic [31:0] b);
        return (a >> ALIGN) == (b >> ALIGN);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic expect1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        bit e_bd, e_bf, e_fd, e_ff, e_dup, e_to;
        int f, d;
        e_bd = (fc[1] >= 0) && (fc[2] >= 0);
        e_bf = 1'b0;
        if (e_bd) begin
            f    = max2(fc[1], fc[2]) + 1;
            e_bf = chk_hist[f] && !m_i[2] && !pc_same(m_r[2], m_w[1]);
        end
        e_fd = (fc[0] >= 0) && (fc[1] >= 0);
        e_ff = 1'b0;
        if (e_fd) begin
            f    = max2(fc[0], fc[1]) + 1;
            e_ff = chk_hist[f] && !m_i[1] && !pc_same(m_r[1], m_w[0]);
        end
        e_dup = dup_j >= 0;
        e_to  = 1'b0;
        if (fc[1] >= 0) begin
            d    = fc[1] + TMO;
            e_to = (cyc > d) && !((fc[2] >= 0) && (fc[2] <= d)) && chk_hist[d];
        end
        expect1("model_bwd_done", bwd_done, e_bd);
        expect1("model_bwd_fail", bwd_fail, e_bf);
        expect1("model_fwd_done", fwd_done, e_fd);
        expect1("model_fwd_fail", fwd_fail, e_ff);
        expect1("model_dup_fail", dup_fail, e_dup);
        expect1("model_timeout_fail", timeout_fail, e_to);
    endtask

    task automatic model_update();
        logic [63:0] keys [3];
        int cnt, first;
        bit dup;
        if (reset) begin
            for (int r = 0; r < 3; r++) fc[r] = -1;
            dup_j = -1;
            return;
        end
        keys[0] = instruction_order - 64'd1;
        keys[1] = instruction_order;
        keys[2] = instruction_order + 64'd1;
        for (int r = 0; r < 3; r++) begin
            cnt   = 0;
            first = -1;
            for (int ch = 0; ch < NRET; ch++) begin
                if (rvfi_valid[ch] && rvfi_order[ch*64 +: 64] == keys[r]) begin
                    cnt++;
                    if (first < 0) first = ch;
                end
            end
            if (cnt > 0) begin
                dup = (cnt > 1) || (fc[r] >= 0);
                if (fc[r] < 0) begin
                    fc[r]  = cyc;
                    m_r[r] = rvfi_pc_rdata[first*32 +: 32];
                    m_w[r] = rvfi_pc_wdata[first*32 +: 32];
                    m_i[r] = rvfi_intr[first];
                end
                if (dup && check && dup_j < 0) dup_j = cyc;
            end
        end
    endtask

    task automatic tick();
        chk_hist[cyc] = check;
        #2;
        if (!reset) compare_cycle();
        model_update();
        @(posedge clock);
        #1;
        cyc++;
        rvfi_valid = '0;
        rvfi_intr  = '0;
    endtask

    task automatic ret(input int ch, input logic [63:0] ord, input logic [31:0] rd,
                       input logic [31:0] wd, input bit intr);
        rvfi_valid[ch]            = 1'b1;
        rvfi_order[ch*64 +: 64]   = ord;
        rvfi_pc_rdata[ch*32 +: 32] = rd;
        rvfi_pc_wdata[ch*32 +: 32] = wd;
        rvfi_intr[ch]             = intr;
    endtask

    task automatic do_reset(input logic [63:0] t);
        instruction_order = t;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pc();
        return 32'h100 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 1));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] t, o;
        int sel;
        reset = 1'b1; check = 1'b1; instruction_order = 64'd10;
        rvfi_valid = '0; rvfi_order = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; rvfi_intr = '0;
        for (int r = 0; r < 3; r++) fc[r] = -1;
        dup_j = -1;
        tick();
        reset = 1'b0;

        // Clean chain 9 -> 10 -> 11.
        do_reset(64'd10);
        expect1("reset_bwd_done", bwd_done, 1'b0);
        expect1("reset_timeout", timeout_fail, 1'b0);
        ret(0, 64'd9, 32'h0, 32'h100, 1'b0);
        ret(1, 64'd10, 32'h100, 32'h104, 1'b0);
        tick();
        expect1("chain_fwd_done", fwd_done, 1'b1);
        expect1("chain_fwd_fail", fwd_fail, 1'b0);
        expect1("chain_bwd_done_early", bwd_done, 1'b0);
        ret(0, 64'd11, 32'h104, 32'h108, 1'b0);
        tick();
        expect1("chain_bwd_done", bwd_done, 1'b1);
        expect1("chain_bwd_fail", bwd_fail, 1'b0);

        // Broken backward link, then the same with the successor as a trap entry.
        do_reset(64'd10);
        ret(0, 64'd9, 32'h0, 32'h100, 1'b0);
        ret(1, 64'd10, 32'h100, 32'h104, 1'b0);
        tick();
        ret(1, 64'd11, 32'h108, 32'h10c, 1'b0);
        tick();
        expect1("bwd_mismatch_fail", bwd_fail, 1'b1);
        do_reset(64'd10);
        ret(0, 64'd9, 32'h0, 32'h100, 1'b0);
        ret(1, 64'd10, 32'h100, 32'h104, 1'b0);
        tick();
        ret(1, 64'd11, 32'h108, 32'h10c, 1'b1);
        tick();
        expect1("bwd_intr_done", bwd_done, 1'b1);
        expect1("bwd_intr_fail", bwd_fail, 1'b0);

        // Reverse retirement order with LSB-only PC differences.
        do_reset(64'd10);
        ret(0, 64'd11, 32'h104, 32'h108, 1'b0);
        tick();
        expect1("rev_bwd_wait", bwd_done, 1'b0);
        ret(1, 64'd10, 32'h100, 32'h105, 1'b0);
        tick();
        expect1("rev_bwd_done", bwd_done, 1'b1);
        expect1("rev_bwd_align", bwd_fail, 1'b0);
        ret(0, 64'd9, 32'h0, 32'h101, 1'b0);
        tick();
        expect1("rev_fwd_done", fwd_done, 1'b1);
        expect1("rev_fwd_align", fwd_fail, 1'b0);

        // Timeout boundary: expiry at c+TMO+1, successor at c+TMO is in time.
        do_reset(64'd10);
        ret(0, 64'd10, 32'h100, 32'h104, 1'b0);
        tick();
        repeat (3) tick();
        expect1("timeout_not_yet", timeout_fail, 1'b0);
        tick();
        expect1("timeout_fires", timeout_fail, 1'b1);
        do_reset(64'd10);
        ret(1, 64'd10, 32'h100, 32'h104, 1'b0);
        tick();
        repeat (3) tick();
        ret(0, 64'd11, 32'h104, 32'h108, 1'b0);
        tick();
        expect1("late_succ_bwd_done", bwd_done, 1'b1);
        repeat (4) tick();
        expect1("late_succ_no_timeout", timeout_fail, 1'b0);

        // Same-cycle duplicate target: ch0 record is kept.
        do_reset(64'd10);
        ret(0, 64'd10, 32'h100, 32'h104, 1'b0);
        ret(1, 64'd10, 32'h200, 32'h204, 1'b0);
        tick();
        expect1("dup_flag", dup_fail, 1'b1);
        ret(0, 64'd11, 32'h104, 32'h0, 1'b0);
        tick();
        expect1("dup_ch0_bwd_done", bwd_done, 1'b1);
        expect1("dup_ch0_bwd_fail", bwd_fail, 1'b0);
        do_reset(64'd10);
        check = 1'b0;
        ret(0, 64'd10, 32'h100, 32'h104, 1'b0);
        ret(1, 64'd10, 32'h200, 32'h204, 1'b0);
        tick();
        check = 1'b1;
        tick();
        expect1("dup_nocheck", dup_fail, 1'b0);

        // Reset between target and successor wipes the target.
        do_reset(64'd10);
        ret(0, 64'd9, 32'h0, 32'h100, 1'b0);
        ret(1, 64'd10, 32'h100, 32'h104, 1'b0);
        tick();
        expect1("pre_reset_fwd_done", fwd_done, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect1("midreset_fwd_done", fwd_done, 1'b0);
        expect1("midreset_dup", dup_fail, 1'b0);
        ret(0, 64'd11, 32'h108, 32'h10c, 1'b0);
        tick();
        expect1("post_reset_bwd_done", bwd_done, 1'b0);
        expect1("post_reset_bwd_fail", bwd_fail, 1'b0);
        repeat (6) tick();
        expect1("post_reset_timeout", timeout_fail, 1'b0);

        // Randomized episodes, including order wrap at T=0 and T=all-ones.
        for (int e = 0; e < 48; e++) begin
            case (e % 4)
                0: t = 64'd10;
                1: t = 64'd0;
                2: t = '1;
                default: t = {$urandom, $urandom};
            endcase
            do_reset(t);
            for (int k = 0; k < 30; k++) begin
                check = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 59) == 0) reset = 1'b1;
                for (int ch = 0; ch < NRET; ch++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        sel = $urandom_range(0, 4);
                        case (sel)
                            0: o = t - 64'd1;
                            1: o = t;
                            2: o = t + 64'd1;
                            3: o = t + 64'd2;
                            default: o = {$urandom, $urandom};
                        endcase
                        ret(ch, o, rnd_pc(), rnd_pc(), $urandom_range(0, 7) == 0);
                    end
                end
                tick();
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
